// File: rtl/rv32i_timer_pkg.sv
// Shared definitions for the rv32i machine timer: halfword register indices,
// control bit positions, reset constants and a halfword-select helper.
package rv32i_timer_pkg;

    localparam int PORT_LEN = 16;

    localparam logic [3:0] MTIME_0    = 4'd0;
    localparam logic [3:0] MTIME_1    = 4'd1;
    localparam logic [3:0] MTIME_2    = 4'd2;
    localparam logic [3:0] MTIME_3    = 4'd3;
    localparam logic [3:0] MTIMECMP_0 = 4'd4;
    localparam logic [3:0] MTIMECMP_1 = 4'd5;
    localparam logic [3:0] MTIMECMP_2 = 4'd6;
    localparam logic [3:0] MTIMECMP_3 = 4'd7;
    localparam logic [3:0] CTRL       = 4'd8;
    localparam logic [3:0] PRESCALE   = 4'd9;

    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_PENDING_BIT = 1;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [PORT_LEN-1:0] halfword(input logic [63:0] value,
                                                     input logic [1:0]  sel);
        return value[sel*PORT_LEN +: PORT_LEN];
    endfunction

endpackage

// File: rtl/rv32i_timer_if.sv
// Bus-side port bundle of the timer: strobes, halfword index, data and interrupt.
interface rv32i_timer_if;
    import rv32i_timer_pkg::*;

    logic                write_i;
    logic                read_i;
    logic [3:0]          addr_i;
    logic [PORT_LEN-1:0] data_i;
    logic [PORT_LEN-1:0] data_o;
    logic                irq_o;

    modport master (output write_i, read_i, addr_i, data_i, input  data_o, irq_o);
    modport slave  (input  write_i, read_i, addr_i, data_i, output data_o, irq_o);

endinterface

// File: rtl/rv32i_timer_prescaler.sv
// Tick divider for the timer: one-cycle tick every value_i+1 enabled cycles.
// Only built when RV32I_TIMER_PRESCALER_EN is defined.
`ifdef RV32I_TIMER_PRESCALER_EN
module timer_prescaler #(
    parameter int PRESCALE_BITS = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     load_i,
    input  logic [PRESCALE_BITS-1:0] value_i,
    output logic                     tick_o
);

    logic [PRESCALE_BITS-1:0] count_q;

    assign tick_o = enable_i && (count_q == value_i);

    // Counter sits at zero while disabled so the first tick lands P cycles after enable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i || !enable_i || tick_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + PRESCALE_BITS'(1);
        end
    end

endmodule
`endif

// File: rtl/rv32i_timer.sv
// Memory-mapped 64-bit machine timer with halfword snapshot reads and staged writes.
// Optional tick divider at index 9 is enabled by defining RV32I_TIMER_PRESCALER_EN.
module rv32i_timer
    import rv32i_timer_pkg::*;
#(
    parameter int PRESCALE_BITS = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    rv32i_timer_if.slave bus
);

    logic [63:0]         mtime_q, mtime_d;
    logic [63:0]         mtimecmp_q, mtimecmp_d;
    logic [63:0]         mtime_shadow_q;
    logic [63:0]         mtimecmp_shadow_q;
    logic [47:0]         mtime_stage_q;
    logic [47:0]         mtimecmp_stage_q;
    logic                enable_q;
    logic                irq_q;
    logic [PORT_LEN-1:0] data_q;
    logic [PORT_LEN-1:0] rdata;
    logic                tick;
    logic                commit_mtime;
    logic                commit_mtimecmp;
    logic [PRESCALE_BITS-1:0] prescale_rd;

    assign commit_mtime    = bus.write_i && (bus.addr_i == MTIME_3);
    assign commit_mtimecmp = bus.write_i && (bus.addr_i == MTIMECMP_3);

`ifdef RV32I_TIMER_PRESCALER_EN
    logic [PRESCALE_BITS-1:0] prescale_q;
    logic                     prescale_load;

    assign prescale_load = bus.write_i && (bus.addr_i == PRESCALE);
    assign prescale_rd   = prescale_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prescale_q <= '0;
        end else if (prescale_load) begin
            prescale_q <= PRESCALE_BITS'(bus.data_i);
        end
    end

    timer_prescaler #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_prescaler (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable_i (enable_q),
        .load_i   (prescale_load),
        .value_i  (prescale_q),
        .tick_o   (tick)
    );
`else
    assign tick        = enable_q;
    assign prescale_rd = '0;
`endif

    // Index 0 and 4 read live; the upper halfwords come from the snapshot taken then.
    always_comb begin
        rdata = '0;
        case (bus.addr_i)
            MTIME_0:                         rdata = mtime_q[PORT_LEN-1:0];
            MTIME_1, MTIME_2, MTIME_3:       rdata = halfword(mtime_shadow_q, bus.addr_i[1:0]);
            MTIMECMP_0:                      rdata = mtimecmp_q[PORT_LEN-1:0];
            MTIMECMP_1, MTIMECMP_2, MTIMECMP_3:
                                             rdata = halfword(mtimecmp_shadow_q, bus.addr_i[1:0]);
            CTRL: begin
                rdata[CTRL_ENABLE_BIT]  = enable_q;
                rdata[CTRL_PENDING_BIT] = irq_q;
            end
            PRESCALE:                        rdata = PORT_LEN'(prescale_rd);
            default:                         rdata = '0;
        endcase
    end

    // A commit to mtime overrides a coincident tick.
    always_comb begin
        mtime_d = mtime_q;
        if (commit_mtime) begin
            mtime_d = {bus.data_i, mtime_stage_q};
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        mtimecmp_d = commit_mtimecmp ? {bus.data_i, mtimecmp_stage_q} : mtimecmp_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mtime_q           <= '0;
            mtimecmp_q        <= MTIMECMP_RESET;
            mtime_shadow_q    <= '0;
            mtimecmp_shadow_q <= '0;
            mtime_stage_q     <= '0;
            mtimecmp_stage_q  <= '0;
            enable_q          <= 1'b0;
            irq_q             <= 1'b0;
            data_q            <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= enable_q && (mtime_q >= mtimecmp_q);

            if (bus.read_i) begin
                data_q <= rdata;
                if (bus.addr_i == MTIME_0) begin
                    mtime_shadow_q <= mtime_q;
                end
                if (bus.addr_i == MTIMECMP_0) begin
                    mtimecmp_shadow_q <= mtimecmp_q;
                end
            end

            if (bus.write_i) begin
                case (bus.addr_i)
                    MTIME_0:    mtime_stage_q[15:0]     <= bus.data_i;
                    MTIME_1:    mtime_stage_q[31:16]    <= bus.data_i;
                    MTIME_2:    mtime_stage_q[47:32]    <= bus.data_i;
                    MTIMECMP_0: mtimecmp_stage_q[15:0]  <= bus.data_i;
                    MTIMECMP_1: mtimecmp_stage_q[31:16] <= bus.data_i;
                    MTIMECMP_2: mtimecmp_stage_q[47:32] <= bus.data_i;
                    CTRL:       enable_q <= bus.data_i[CTRL_ENABLE_BIT];
                    default:    ;
                endcase
            end
        end
    end

    assign bus.data_o = data_q;
    assign bus.irq_o  = irq_q;

endmodule
